mem_bus_decoder: RTL and testbench

Registered, parametrised address decoder and response handshake between the multicycle core's data port and N memory-mapped slaves (RAM, PID, ADC, timer, display, port latch, …). Each request is decoded once against per-slave [base, limit) windows and the selection is latched. The selected chip-select is then held until the slave signals ready, and the slave's read data is returned with a one-cycle ready pulse. Unmapped, conflicting and (optionally) timed-out accesses terminate with an error pulse instead of hanging the core.

---
 rtl/mem_bus_decoder_if.sv | 29 ++
 rtl/mem_bus_decoder.sv | 185 ++++++++++++++++++
 tb/tb_mem_bus_decoder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_decoder_if.sv
// Core data port and slave-side bus bundle for mem_bus_decoder.
// master: core plus slave models; slave: the decoder itself.
interface mem_bus_decoder_if #(
  parameter int unsigned N_SLAVES = 7,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
);
  logic                         cpu_read;
  logic                         cpu_write;
  logic [ADDR_W-1:0]            cpu_addr;
  logic [DATA_W-1:0]            cpu_rdata;
  logic                         cpu_ready;
  logic                         cpu_err;
  logic                         busy;
  logic [N_SLAVES-1:0]          slv_cs;
  logic                         slv_we;
  logic [N_SLAVES-1:0]          slv_ready;
  logic [N_SLAVES*DATA_W-1:0]   slv_rdata;

  modport master (
    output cpu_read, cpu_write, cpu_addr, slv_ready, slv_rdata,
    input  cpu_rdata, cpu_ready, cpu_err, busy, slv_cs, slv_we
  );

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, slv_ready, slv_rdata,
    output cpu_rdata, cpu_ready, cpu_err, busy, slv_cs, slv_we
  );
endinterface

// File: rtl/mem_bus_decoder.sv
// Registered address decoder and ready/error handshake between the core data port and N slaves.
// Optional ACCESS watchdog enabled by defining MEM_BUS_DEC_TIMEOUT_EN.
module mem_bus_decoder #(
  parameter int unsigned N_SLAVES = 7,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = {
    32'hC000_00AC, 32'hC000_00A8, 32'hC000_0080, 32'hC000_0078,
    32'hC000_0040, 32'hC000_0000, 32'h1000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_LIMIT = {
    32'hC000_00B0, 32'hC000_00AC, 32'hC000_00A8, 32'hC000_0080,
    32'hC000_0078, 32'hC000_0040, 32'hC000_0000},
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_bus_decoder_if.slave    bus
);

  localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_n_slaves
    $error("mem_bus_decoder: N_SLAVES must be in 1..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_bus_decoder: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e               state_q,  state_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [N_SLAVES-1:0]  cs_q,     cs_d;
  logic                 we_q,     we_d;
  logic                 ready_q,  ready_d;
  logic                 err_q,    err_d;
  logic                 busy_q,   busy_d;
  logic [DATA_W-1:0]    rdata_q,  rdata_d;

`ifdef MEM_BUS_DEC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]     tmo_q,    tmo_d;
`endif

  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;
  logic                 sel_ready;
  logic [DATA_W-1:0]    sel_rdata;

  // Window decode; scanning from the top lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((bus.cpu_addr >= SLV_BASE[i*ADDR_W +: ADDR_W]) &&
          (bus.cpu_addr <  SLV_LIMIT[i*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Only the latched slave's ready and data are observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = bus.slv_ready[i];
        sel_rdata = bus.slv_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cs_d    = cs_q;
    we_d    = we_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
`ifdef MEM_BUS_DEC_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_read && bus.cpu_write) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else if (bus.cpu_read || bus.cpu_write) begin
          if (hit) begin
            state_d = ST_ACCESS;
            idx_d   = hit_idx;
            cs_d    = N_SLAVES'(1) << hit_idx;
            we_d    = bus.cpu_write;
`ifdef MEM_BUS_DEC_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        if (sel_ready) begin
          state_d = ST_RESP;
          cs_d    = '0;
          ready_d = 1'b1;
          if (!we_q) begin
            rdata_d = sel_rdata;
          end
        end
`ifdef MEM_BUS_DEC_TIMEOUT_EN
        // Ready in the final window cycle still completes normally.
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          cs_d    = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          tmo_d   = TMO_W'(TIMEOUT);
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
`endif
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cs_q    <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_BUS_DEC_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
`ifdef MEM_BUS_DEC_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.slv_cs    = cs_q;
  assign bus.slv_we    = we_q;
  assign bus.cpu_ready = ready_q;
  assign bus.cpu_err   = err_q;
  assign bus.busy      = busy_q;
  assign bus.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed and randomized checks of mem_bus_decoder against a window/latency reference model.
module tb_mem_bus_decoder;
  localparam int NS      = 7;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] model_rdata;

  logic [31:0] base_a  [NS] = '{32'h1000_0000, 32'hC000_0000, 32'hC000_0040, 32'hC000_0078,
                                 32'hC000_0080, 32'hC000_00A8, 32'hC000_00AC};
  logic [31:0] limit_a [NS] = '{32'hC000_0000, 32'hC000_0040, 32'hC000_0078, 32'hC000_0080,
                                 32'hC000_00A8, 32'hC000_00AC, 32'hC000_00B0};

  mem_bus_decoder_if #(.N_SLAVES(NS), .ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_decoder #(.N_SLAVES(NS), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First window containing addr, or -1 when unmapped.
  function automatic int decode(input logic [31:0] addr);
    for (int i = 0; i < NS; i++)
      if (addr >= base_a[i] && addr < limit_a[i]) return i;
    return -1;
  endfunction

  // One request; wt = wait cycles before slave ready, negative = never ready.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input int wt, input logic [31:0] data);
    int e;
    int k;
    bit tmo;
    e = (rd && wr) ? -1 : decode(addr);
    chk("idle_busy", 64'(bus.busy), 64'(0));
    bus.cpu_read  = rd;
    bus.cpu_write = wr;
    bus.cpu_addr  = addr;
    step();
    bus.cpu_read  = 1'($urandom_range(0, 1));
    bus.cpu_write = 1'($urandom_range(0, 1));
    bus.cpu_addr  = $urandom();
    if (e < 0) begin
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      chk("err_ready", 64'(bus.cpu_ready), 64'(1));
      chk("err_err",   64'(bus.cpu_err),   64'(1));
      chk("err_cs",    64'(bus.slv_cs),    64'(0));
      chk("err_rdata", 64'(bus.cpu_rdata), 64'(model_rdata));
    end else begin
      tmo = 1'b0;
      k   = 1 + wt;
`ifdef MEM_BUS_DEC_TIMEOUT_EN
      if (wt < 0 || wt >= TIMEOUT) begin
        tmo = 1'b1;
        k   = TIMEOUT;
      end
`else
      if (wt < 0) k = 41;
`endif
      for (int c = 1; c <= k; c++) begin
        chk("acc_cs",    64'(bus.slv_cs),    64'(7'(1) << e));
        chk("acc_we",    64'(bus.slv_we),    64'(wr));
        chk("acc_ready", 64'(bus.cpu_ready), 64'(0));
        chk("acc_busy",  64'(bus.busy),      64'(1));
        bus.slv_rdata = {$urandom(), $urandom(), $urandom(), $urandom(),
                         $urandom(), $urandom(), $urandom()};
        bus.slv_ready = 7'($urandom()) & ~(7'(1) << e);
        if (c == k && !tmo) begin
          bus.slv_ready[e]          = 1'b1;
          bus.slv_rdata[e*32 +: 32] = data;
        end
        step();
      end
      bus.slv_ready = '0;
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      if (!tmo && rd) model_rdata = data;
      chk("resp_ready", 64'(bus.cpu_ready), 64'(1));
      chk("resp_err",   64'(bus.cpu_err),   64'(tmo));
      chk("resp_cs",    64'(bus.slv_cs),    64'(0));
      chk("resp_rdata", 64'(bus.cpu_rdata), 64'(model_rdata));
      chk("resp_busy",  64'(bus.busy),      64'(1));
    end
    step();
    chk("post_ready", 64'(bus.cpu_ready), 64'(0));
    chk("post_err",   64'(bus.cpu_err),   64'(0));
    chk("post_busy",  64'(bus.busy),      64'(0));
    chk("post_cs",    64'(bus.slv_cs),    64'(0));
    chk("post_rdata", 64'(bus.cpu_rdata), 64'(model_rdata));
  endtask

  initial begin
    int sel;
    int s;
    bit rd;
    logic [31:0] a;
    total = 0;
    bad = 0;
    model_rdata = '0;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_addr = '0;
    bus.slv_ready = '0;
    bus.slv_rdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_cs",    64'(bus.slv_cs),    64'(0));
    chk("rst_we",    64'(bus.slv_we),    64'(0));
    chk("rst_ready", 64'(bus.cpu_ready), 64'(0));
    chk("rst_err",   64'(bus.cpu_err),   64'(0));
    chk("rst_busy",  64'(bus.busy),      64'(0));
    chk("rst_rdata", 64'(bus.cpu_rdata), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    txn(1, 0, 32'h1000_0004, 0, 32'hDEAD_BEEF);
    txn(0, 1, 32'hC000_00A8, 4, 32'h1234_5678);
    txn(1, 0, 32'h0000_0100, 0, 32'h0);
    txn(1, 1, 32'hC000_0000, 0, 32'h0);
    txn(1, 0, 32'hC000_0078, -1, 32'hA5A5_0078);
    txn(1, 0, 32'hC000_00AF, 2, 32'hCAFE_00AF);
    txn(1, 0, 32'hC000_00B0, 0, 32'h0);
    txn(0, 1, 32'h0FFF_FFFF, 0, 32'h0);
    txn(1, 0, 32'hBFFF_FFFF, 1, 32'h0BAD_F00D);

    // Reset in the third ACCESS cycle aborts without a response pulse.
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 32'hC000_0040;
    step();
    bus.cpu_read = 1'b0;
    chk("rst_acc_cs1", 64'(bus.slv_cs), 64'(7'b0000100));
    step();
    step();
    chk("rst_acc_cs3", 64'(bus.slv_cs), 64'(7'b0000100));
    #2 rst_n = 1'b0;
    #1;
    model_rdata = '0;
    chk("rst_mid_cs",    64'(bus.slv_cs),    64'(0));
    chk("rst_mid_ready", 64'(bus.cpu_ready), 64'(0));
    chk("rst_mid_busy",  64'(bus.busy),      64'(0));
    chk("rst_mid_rdata", 64'(bus.cpu_rdata), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("rst_after_ready", 64'(bus.cpu_ready), 64'(0));
    txn(1, 0, 32'hC000_0050, 0, 32'h5A5A_0050);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      rd  = 1'($urandom_range(0, 1));
      if (sel == 0) begin
        txn(1, 1, $urandom(), 0, 32'h0);
      end else if (sel == 1) begin
        a = {4'h0, 28'($urandom())};
        if ($urandom_range(0, 1) == 1) a = 32'hC000_00B0 + 32'($urandom_range(0, 255));
        txn(rd, !rd, a, 0, 32'h0);
      end else begin
        s = $urandom_range(0, NS - 1);
        case ($urandom_range(0, 2))
          0:       a = base_a[s];
          1:       a = limit_a[s] - 32'd1;
          default: a = base_a[s] + ($urandom() % (limit_a[s] - base_a[s]));
        endcase
        txn(rd, !rd, a, $urandom_range(0, 5), $urandom());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
